// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for a 16-bit accumulator CPU: fetch, decode, operand read, execute, store.
// Optional feature: define CU_MULDIV_EN to make opcodes 0x08/0x09 executable memory operations.
module cpu_control_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   input  logic        acc_sign,
   output logic        mem_req,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [7:0]  pc,
   output logic [7:0]  fn,
   output logic        c7,
   output logic        c14,
   output logic        acc_we,
   output logic        halted,
   output logic        illegal,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_STORE, S_HALT
   } state_t;

   state_t      r_state;
   logic [15:0] r_ir;
   logic [7:0]  r_pc;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [7:0]  r_mem_addr;
   logic [7:0]  r_fn;
   logic        r_c7;
   logic        r_c14;
   logic        r_acc_we;
   logic        r_halted;
   logic        r_illegal;

   logic [7:0]  w_op;
   logic [7:0]  w_x;
   logic        w_is_read;
   logic        w_hs;

   assign w_op = r_ir[15:8];
   assign w_x  = r_ir[7:0];
   // Memory handshake: mem_req/mem_we/mem_addr hold until mem_ack is sampled with mem_req high;
   // mem_req is low the cycle after, and mem_ack seen while mem_req is low is ignored.
   assign w_hs = r_mem_req & mem_ack;

   always_comb begin
      w_is_read = 1'b0;
      case (w_op)
         8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C: w_is_read = 1'b1;
`ifdef CU_MULDIV_EN
         8'h08, 8'h09:                             w_is_read = 1'b1;
`endif
         default:                                  w_is_read = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ir       <= 16'h0000;
         r_pc       <= 8'h00;
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= 8'h00;
         r_fn       <= 8'h00;
         r_c7       <= 1'b0;
         r_c14      <= 1'b0;
         r_acc_we   <= 1'b0;
         r_halted   <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_fn     <= 8'h00;
         r_c7     <= 1'b0;
         r_c14    <= 1'b0;
         r_acc_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (run) begin
                  r_state    <= S_FETCH;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= r_pc;
               end
            end
            S_FETCH: begin
               if (w_hs) begin
                  r_ir      <= mem_rdata;
                  r_pc      <= r_pc + 8'd1;
                  r_mem_req <= 1'b0;
                  r_state   <= S_DECODE;
               end else begin
                  // Also raises the request after the idle cycle that follows a store.
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= r_pc;
               end
            end
            S_DECODE: begin
               if (w_is_read) begin
                  r_state    <= S_READ;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= w_x;
               end else begin
                  case (w_op)
                     8'h0D, 8'h0E, 8'h0F: begin
                        r_state  <= S_EXEC;
                        r_fn     <= w_op;
                        r_c14    <= 1'b1;
                        r_acc_we <= 1'b1;
                     end
                     8'h01: begin
                        r_state    <= S_STORE;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_x;
                     end
                     8'h05: begin
                        r_state   <= S_FETCH;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                        if (!acc_sign) begin
                           r_pc       <= w_x;
                           r_mem_addr <= w_x;
                        end else begin
                           r_mem_addr <= r_pc;
                        end
                     end
                     8'h06: begin
                        r_state    <= S_FETCH;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_pc       <= w_x;
                        r_mem_addr <= w_x;
                     end
                     8'h07: begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                     end
                     default: begin
                        r_state   <= S_HALT;
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                     end
                  endcase
               end
            end
            S_READ: begin
               if (w_hs) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_EXEC;
                  r_fn      <= w_op;
                  r_c7      <= (w_op == 8'h02) || (w_op == 8'h0C);
                  r_acc_we  <= 1'b1;
               end
            end
            S_EXEC: begin
               r_state    <= S_FETCH;
               r_mem_req  <= 1'b1;
               r_mem_we   <= 1'b0;
               r_mem_addr <= r_pc;
            end
            S_STORE: begin
               if (w_hs) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_state   <= S_FETCH;
               end
            end
            S_HALT: begin
               r_halted <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign pc          = r_pc;
   assign fn          = r_fn;
   assign c7          = r_c7;
   assign c14         = r_c14;
   assign acc_we      = r_acc_we;
   assign halted      = r_halted;
   assign illegal     = r_illegal;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: an instruction-level model predicts the memory
// transactions and ALU strobes; a per-cycle compare process checks the DUT against it.
module tb_cpu_control_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [15:0] mem_rdata = 16'h0000;
   logic        mem_ack = 1'b0;
   logic        acc_sign = 1'b0;
   logic        mem_req, mem_we, c7, c14, acc_we, halted, illegal;
   logic [7:0]  mem_addr, pc, fn;
   logic [2:0]  dbg_state;

   cpu_control_unit dut (
      .clk(clk), .rst(rst), .run(run), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .acc_sign(acc_sign), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .pc(pc), .fn(fn), .c7(c7), .c14(c14), .acc_we(acc_we), .halted(halted),
      .illegal(illegal), .o_dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

`ifdef CU_MULDIV_EN
   localparam bit MULDIV = 1'b1;
`else
   localparam bit MULDIV = 1'b0;
`endif

   // ---------------- memory responder ----------------
   logic [15:0] mem [256];
   bit mem_en = 1'b0;
   int busy = 0;
   int cnt = 0;
   int wait_min = 0;
   int wait_max = 0;

   always @(negedge clk) begin
      if (mem_en) begin
         mem_ack = 1'b0;
         if (busy == 0 && mem_req) begin
            busy = 1;
            cnt  = $urandom_range(wait_max, wait_min);
         end else if (busy != 0) begin
            if (cnt == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = mem[mem_addr];
               busy      = 0;
            end else begin
               cnt--;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   // mem_q entry: {is_fetch, we, addr}; exec_q entry: {c7, c14, fn}
   logic [9:0] mem_q[$];
   logic [9:0] exec_q[$];
   int         fetch_rise_q[$];
   int         read_rise_q[$];
   int         read_ack_q[$];
   int         store_ack_q[$];
   int         exec_cyc_q[$];
   logic [7:0] exec_fn_q[$];

   task automatic clear_queues();
      mem_q.delete(); exec_q.delete(); fetch_rise_q.delete(); read_rise_q.delete();
      read_ack_q.delete(); store_ack_q.delete(); exec_cyc_q.delete(); exec_fn_q.delete();
   endtask

   // Instruction-set interpreter: walks the program and lists what the bus and ALU must see.
   task automatic build_model(input bit sign, output bit done, output bit ill, output logic [7:0] fpc);
      logic [7:0]  p;
      logic [15:0] ir;
      logic [7:0]  op;
      logic [7:0]  x;
      p = 8'h00; done = 1'b0; ill = 1'b0;
      for (int n = 0; n < 150 && !done; n++) begin
         ir = mem[p];
         mem_q.push_back({2'b10, p});
         p  = p + 8'd1;
         op = ir[15:8];
         x  = ir[7:0];
         if ((op inside {8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C}) ||
             (MULDIV && (op inside {8'h08, 8'h09}))) begin
            mem_q.push_back({2'b00, x});
            exec_q.push_back({(op == 8'h02 || op == 8'h0C), 1'b0, op});
         end else if (op inside {8'h0D, 8'h0E, 8'h0F}) begin
            exec_q.push_back({1'b0, 1'b1, op});
         end else if (op == 8'h01) begin
            mem_q.push_back({2'b01, x});
         end else if (op == 8'h05) begin
            if (!sign) p = x;
         end else if (op == 8'h06) begin
            p = x;
         end else if (op == 8'h07) begin
            done = 1'b1;
         end else begin
            done = 1'b1;
            ill  = 1'b1;
         end
      end
      fpc = p;
   endtask

   // ---------------- compare process ----------------
   bit         chk_en = 1'b0;
   int         cyc = 0;
   int         rise_cyc = 0;
   logic       prev_req = 1'b0;
   logic       prev_we = 1'b0;
   logic [7:0] prev_addr = 8'h00;
   logic       prev_hs = 1'b0;
   logic       prev_acc_we = 1'b0;

   always @(negedge clk) begin
      logic [9:0] e;
      logic       hs;
      #1;
      cyc++;
      if (rst || !chk_en) begin
         prev_req = 1'b0; prev_hs = 1'b0; prev_acc_we = 1'b0;
      end else begin
         hs = mem_req & mem_ack;
         if (prev_hs) chk("req_low_after_ack", mem_req, 1'b0);
         else if (prev_req) begin
            chk("req_held", mem_req, 1'b1);
            chk("we_held", mem_we, prev_we);
            chk("addr_held", mem_addr, prev_addr);
         end
         if (mem_req && !prev_req) rise_cyc = cyc;
         if (hs) begin
            if (mem_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL mem_txn_unexpected actual=addr %0h we %0b required=no transfer", mem_addr, mem_we);
            end else begin
               e = mem_q.pop_front();
               chk("mem_we", mem_we, e[8]);
               chk("mem_addr", mem_addr, e[7:0]);
               if (e[9]) begin
                  chk("fetch_pc", pc, e[7:0]);
                  fetch_rise_q.push_back(rise_cyc);
               end else if (e[8]) store_ack_q.push_back(cyc);
               else begin
                  read_rise_q.push_back(rise_cyc);
                  read_ack_q.push_back(cyc);
               end
            end
         end
         if (acc_we) begin
            chk("acc_we_single", prev_acc_we, 1'b0);
            exec_cyc_q.push_back(cyc);
            exec_fn_q.push_back(fn);
            if (exec_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL exec_unexpected actual=fn %0h required=no exec", fn);
            end else begin
               e = exec_q.pop_front();
               chk("exec_fn", fn, e[7:0]);
               chk("exec_c7", c7, e[9]);
               chk("exec_c14", c14, e[8]);
            end
         end else chk("alu_idle", {fn, c7, c14}, 10'h000);
         if (halted) chk("halt_no_req", mem_req, 1'b0);
         prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr;
         prev_hs = hs; prev_acc_we = acc_we;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      chk_en = 1'b0; mem_en = 1'b0; run = 1'b0; rst = 1'b1; mem_ack = 1'b0; busy = 0;
      tick(); tick();
      clear_queues();
      rst = 1'b0;
      tick();
      mem_en = 1'b1; chk_en = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_mem_req"}, mem_req, 1'b0);
      chk({tag, "_mem_we"}, mem_we, 1'b0);
      chk({tag, "_mem_addr"}, mem_addr, 8'h00);
      chk({tag, "_pc"}, pc, 8'h00);
      chk({tag, "_fn"}, fn, 8'h00);
      chk({tag, "_c7c14"}, {c7, c14}, 2'b00);
      chk({tag, "_acc_we"}, acc_we, 1'b0);
      chk({tag, "_halted"}, halted, 1'b0);
      chk({tag, "_illegal"}, illegal, 1'b0);
   endtask

   task automatic clear_mem();
      for (int a = 0; a < 256; a++) mem[a] = 16'h0700;
   endtask

   task automatic run_prog(input bit sign, input int wmin, input int wmax, input string tag);
      bit         done;
      bit         ill;
      logic [7:0] fpc;
      int         budget;
      do_reset();
      acc_sign = sign; wait_min = wmin; wait_max = wmax;
      build_model(sign, done, ill, fpc);
      run = 1'b1;
      budget = done ? 2000 : 400;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (i == 2) run = 1'b0;
         if (halted) break;
      end
      if (done) begin
         chk({tag, "_halted"}, halted, 1'b1);
         chk({tag, "_illegal"}, illegal, ill);
         chk({tag, "_pc"}, pc, fpc);
         chk({tag, "_mem_q_left"}, mem_q.size(), 0);
         chk({tag, "_exec_q_left"}, exec_q.size(), 0);
      end else begin
         chk({tag, "_running"}, halted, 1'b0);
      end
   endtask

   task automatic fill_random();
      int         r;
      logic [7:0] op;
      for (int a = 0; a < 256; a++) begin
         r = $urandom_range(0, 99);
         if (r < 4)       op = 8'h00;
         else if (r < 8)  op = 8'($urandom_range(16, 255));
         else if (r < 14) op = 8'h07;
         else             op = 8'($urandom_range(1, 15));
         mem[a] = {op, 8'($urandom_range(0, 255))};
      end
   endtask

   // ---------------- tests ----------------
   initial begin
      bit         m_done;
      bit         m_ill;
      logic [7:0] m_pc;
      bit         found;

      do_reset();
      check_reset_outputs("reset");

      // Reference program: model pinned by hand, then run on the DUT.
      clear_mem();
      mem[0] = 16'h0205; mem[1] = 16'h0306; mem[2] = 16'h0107; mem[3] = 16'h0700;
      mem[5] = 16'h0003; mem[6] = 16'h0004;
      clear_queues();
      build_model(1'b0, m_done, m_ill, m_pc);
      chk("pin_exec0", exec_q[0], {1'b1, 1'b0, 8'h02});
      chk("pin_exec1", exec_q[1], {1'b0, 1'b0, 8'h03});
      chk("pin_mem_count", mem_q.size(), 7);
      chk("pin_store", mem_q[5], {2'b01, 8'h07});
      chk("pin_done_pc", {m_done, m_ill, m_pc}, {1'b1, 1'b0, 8'h04});
      run_prog(1'b0, 0, 2, "prog");
      chk("prog_final_pc", pc, 8'h04);
      chk("prog_final_halted", halted, 1'b1);

      // Cycle counts with zero-wait memory.
      clear_mem();
      mem[0] = 16'h0D00; mem[1] = 16'h0205; mem[2] = 16'h0604; mem[4] = 16'h0107; mem[5] = 16'h0700;
      run_prog(1'b0, 0, 0, "timing");
      if (fetch_rise_q.size() >= 4 && exec_cyc_q.size() >= 2 && store_ack_q.size() >= 1) begin
         chk("cycles_reg_op", exec_cyc_q[0] - fetch_rise_q[0] + 1, 4);
         chk("cycles_mem_op", exec_cyc_q[1] - fetch_rise_q[1] + 1, 6);
         chk("cycles_jump", fetch_rise_q[3] - fetch_rise_q[2], 3);
         chk("cycles_store", store_ack_q[0] - fetch_rise_q[3] + 1, 5);
      end else begin
         checks++; errors++;
         $display("FAIL timing_events actual=%0d fetches required=5", fetch_rise_q.size());
      end

      // Conditional jump on both signs: no operand read either way.
      clear_mem();
      mem[0] = 16'h0510;
      run_prog(1'b0, 0, 1, "jn_pos");
      chk("jn_pos_pc", pc, 8'h11);
      chk("jn_pos_no_read", read_ack_q.size(), 0);
      run_prog(1'b1, 0, 1, "jn_neg");
      chk("jn_neg_pc", pc, 8'h02);
      chk("jn_neg_no_read", read_ack_q.size(), 0);

      // Slow memory during READ: request held, EXEC one cycle after ack.
      clear_mem();
      mem[0] = 16'h0205;
      run_prog(1'b0, 5, 5, "slow");
      if (read_ack_q.size() == 1 && exec_cyc_q.size() == 1) begin
         chk("slow_req_length", read_ack_q[0] - read_rise_q[0], 6);
         chk("slow_exec_after_ack", exec_cyc_q[0] - read_ack_q[0], 1);
      end else begin
         checks++; errors++;
         $display("FAIL slow_events actual=%0d reads required=1", read_ack_q.size());
      end

      // pc wrap from 0xFF.
      clear_mem();
      mem[0] = 16'h06FF; mem[255] = 16'h0D00;
      do_reset();
      wait_min = 0; wait_max = 0;
      build_model(1'b0, m_done, m_ill, m_pc);
      run = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (i == 2) run = 1'b0;
         if (acc_we) begin found = 1'b1; break; end
      end
      chk("wrap_exec_seen", found, 1'b1);
      chk("wrap_pc", pc, 8'h00);
      chk("wrap_fn", fn, 8'h0D);
      chk("wrap_c14", c14, 1'b1);
      tick();
      chk("wrap_acc_we_once", acc_we, 1'b0);

      // Opcode 0x08 depends on the build option.
      clear_mem();
      mem[0] = 16'h0800;
      run_prog(1'b0, 0, 1, "op08");
`ifdef CU_MULDIV_EN
      chk("op08_exec_count", exec_fn_q.size(), 1);
      if (exec_fn_q.size() > 0) chk("op08_fn", exec_fn_q[0], 8'h08);
`else
      chk("op08_illegal", illegal, 1'b1);
      chk("op08_halted", halted, 1'b1);
      chk("op08_no_exec", exec_fn_q.size(), 0);
`endif

      // Reset during a STORE transfer, then a stray ack.
      clear_mem();
      mem[0] = 16'h0107; mem[1] = 16'h0700;
      do_reset();
      wait_min = 6; wait_max = 6;
      build_model(1'b0, m_done, m_ill, m_pc);
      run = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (i == 2) run = 1'b0;
         if (mem_req && mem_we) begin found = 1'b1; break; end
      end
      chk("rst_store_seen", found, 1'b1);
      chk_en = 1'b0; mem_en = 1'b0; busy = 0;
      rst = 1'b1;
      #1;
      chk("rst_async_req", mem_req, 1'b0);
      chk("rst_async_we", mem_we, 1'b0);
      #1;
      rst = 1'b0;
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      check_reset_outputs("rst_mid");
      clear_queues();
      wait_min = 0; wait_max = 1;
      build_model(1'b0, m_done, m_ill, m_pc);
      mem_en = 1'b1; chk_en = 1'b1; run = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (mem_req) begin found = 1'b1; break; end
      end
      run = 1'b0;
      chk("rst_refetch_seen", found, 1'b1);
      chk("rst_refetch_addr", mem_addr, 8'h00);
      for (int i = 0; i < 60 && !halted; i++) tick();
      chk("rst_rerun_halted", halted, 1'b1);
      chk("rst_rerun_pc", pc, 8'h02);

      // Randomized programs against the model.
      for (int t = 0; t < 12; t++) begin
         fill_random();
         run_prog(1'($urandom_range(0, 1)), 0, 3, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
